bnn_dot_multi: RTL and testbench

- Next-generation XNOR-popcount binary dot-product engine. One activation word stream is shared across P_CH parallel weight lanes, so each job yields P_CH neuron outputs at once.
- Vector length is set at run time per job: n_words beats of WORD_W bits.
- Input and output use valid/ready handshakes.
- Produces signed dot results and binarised (sign or threshold) activations.
- Sits between the activation/weight buffers and the next binary layer's input packer.

---
 rtl/bnn_pkg.sv | 31 +++
 rtl/bnn_xnor_popcnt_lane.sv | 30 +++
 rtl/bnn_dot_multi.sv | 143 ++++++++++++++
 tb/tb_bnn_dot_multi.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary (XNOR-popcount) dot-product blocks:
// FSM state encoding, default widths, and constant/popcount helpers.
package bnn_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int ACC_W_DEF  = 16;
    // Widest word the popcount helper handles; narrower words are zero-extended.
    localparam int POP_MAX_W  = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } bnn_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) n = n + 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/bnn_xnor_popcnt_lane.sv
// One weight lane: XNOR of activation and weight beat, popcount, and a
// clearable/enabled popcount accumulator.
module bnn_xnor_popcnt_lane
    import bnn_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int PC_W   = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [WORD_W-1:0] a_word,
    input  logic [WORD_W-1:0] w_word,
    output logic [PC_W-1:0]   pc
);

    logic [WORD_W-1:0] match;
    logic [PC_W-1:0]   ones;

    assign match = ~(a_word ^ w_word);
    assign ones  = PC_W'(popcount(POP_MAX_W'(match)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pc <= '0;
        else if (clr) pc <= '0;
        else if (en)  pc <= pc + ones;
    end

endmodule

// File: rtl/bnn_dot_multi.sv
// Multi-lane XNOR-popcount dot engine: shared activation stream, P_CH weight lanes.
// Optional per-lane threshold binarisation with BNN_THRESH_EN.
module bnn_dot_multi
    import bnn_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int P_CH      = 4,
    parameter int MAX_WORDS = 64,
    parameter int ACC_W     = ACC_W_DEF,
    localparam int CNT_W    = clog2(MAX_WORDS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       n_words,
`ifdef BNN_THRESH_EN
    input  logic [P_CH*ACC_W-1:0]  thresh,
`endif
    input  logic [WORD_W-1:0]      a_word,
    input  logic [P_CH*WORD_W-1:0] w_words,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [P_CH*ACC_W-1:0]  acc_out,
    output logic [P_CH-1:0]        bin_out,
    output logic                   busy
);

    localparam int PC_W   = CNT_W + clog2(WORD_W + 1);
    localparam int FULL_W = (PC_W + 2 > ACC_W) ? PC_W + 2 : ACC_W;

    bnn_state_e                state;
    logic [CNT_W-1:0]          n_lat;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          n_clamp;
    logic                      accept;
    logic                      clr;
    logic [PC_W-1:0]           pc [P_CH];
    logic signed [FULL_W-1:0]  full_c [P_CH];
    logic signed [ACC_W-1:0]   acc_c [P_CH];
    logic signed [ACC_W-1:0]   thr_c [P_CH];
    logic [P_CH-1:0]           bin_c;
`ifdef BNN_THRESH_EN
    logic [P_CH*ACC_W-1:0]     thresh_lat;
`endif

    function automatic logic signed [ACC_W-1:0] trunc_acc(input logic signed [FULL_W-1:0] v);
        return $signed(v[ACC_W-1:0]);
    endfunction

    assign n_clamp = (n_words > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : n_words;
    assign accept  = in_valid && in_ready;
    assign clr     = (state == IDLE) && start;

    for (genvar c = 0; c < P_CH; c++) begin : g_lane
        bnn_xnor_popcnt_lane #(
            .WORD_W (WORD_W),
            .PC_W   (PC_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr),
            .en     (accept),
            .a_word (a_word),
            .w_word (w_words[c*WORD_W +: WORD_W]),
            .pc     (pc[c])
        );
    end

    // Final arithmetic: 2*matches - total bits, wrapped in unsigned math then reinterpreted.
    always_comb begin
        for (int c = 0; c < P_CH; c++) begin
            full_c[c] = $signed((FULL_W'(pc[c]) << 1) - FULL_W'(n_lat) * FULL_W'(WORD_W));
            acc_c[c]  = trunc_acc(full_c[c]);
`ifdef BNN_THRESH_EN
            thr_c[c]  = $signed(thresh_lat[c*ACC_W +: ACC_W]);
`else
            thr_c[c]  = '0;
`endif
            bin_c[c]  = (acc_c[c] >= thr_c[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_lat     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc_out   <= '0;
            bin_out   <= '0;
`ifdef BNN_THRESH_EN
            thresh_lat <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat <= n_clamp;
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef BNN_THRESH_EN
                        thresh_lat <= thresh;
`endif
                        if (n_clamp != '0) begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state <= FINAL;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt + CNT_W'(1) == n_lat) begin
                            in_ready <= 1'b0;
                            state    <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    for (int c = 0; c < P_CH; c++) acc_out[c*ACC_W +: ACC_W] <= acc_c[c];
                    bin_out   <= bin_c;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_dot_multi.sv
// Directed bench for bnn_dot_multi (default build; threshold case also under BNN_THRESH_EN).
module tb_bnn_dot_multi;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [6:0]   n_words;
    logic [31:0]  a_word;
    logic [127:0] w_words;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  acc_out;
    logic [3:0]   bin_out;
    logic         busy;
`ifdef BNN_THRESH_EN
    logic [63:0]  thresh;
`endif

    int vectors = 0;
    int miscompares = 0;

    bnn_dot_multi dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_words   (n_words),
`ifdef BNN_THRESH_EN
        .thresh    (thresh),
`endif
        .a_word    (a_word),
        .w_words   (w_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .bin_out   (bin_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [6:0] n);
        n_words = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] a, input logic [127:0] w, input int count);
        a_word  = a;
        w_words = w;
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int bound);
        int n;
        n = 0;
        while (!out_valid && n < bound) begin
            tick();
            n++;
        end
        check(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int   accepted;
        int   cyc;
        logic rdy;

        rst_n = 1'b0; start = 1'b0; n_words = '0; a_word = '0; w_words = '0;
        in_valid = 1'b0; out_ready = 1'b0;
`ifdef BNN_THRESH_EN
        thresh = '0;
`endif
        tick(); tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_acc", acc_out, 64'd0);
        check("rst_bin", 64'(bin_out), 64'd0);
        rst_n = 1'b1;
        tick();

        // Sign extremes, single beat
        start_job(7'd1);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        feed(32'hFFFF_FFFF, {32'hAAAA_AAAA, 32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_FFFF}, 1);
        check("t1_final_no_valid", 64'(out_valid), 64'd0);
        wait_out("t1_timeout", 4);
        check("t1_acc", acc_out, 64'h0000_0000_FFE0_0020);
        check("t1_bin", 64'(bin_out), 64'b1101);
        handshake();
        check("t1_busy_after", 64'(busy), 64'd0);

        // Distinct per-lane counts over two beats
        start_job(7'd2);
        feed(32'h0F0F_0F0F, {32'h0000_0000, 32'h0F0F_0F0E, 32'hF0F0_F0F0, 32'h0F0F_0F0F}, 2);
        wait_out("t2_timeout", 4);
        check("t2_acc", acc_out, 64'h0000_003C_FFC0_0040);
        check("t2_bin", 64'(bin_out), 64'b1101);
        handshake();

        // Eight beats with in_valid toggling every cycle
        start_job(7'd8);
        a_word = 32'h1234_5678;
        w_words = {4{32'h1234_5678}};
        accepted = 0;
        cyc = 0;
        while (accepted < 8 && cyc < 40) begin
            in_valid = (cyc % 2 == 0);
            rdy = in_ready;
            tick();
            if (in_valid && rdy) accepted++;
            cyc++;
        end
        in_valid = 1'b0;
        check("t3_beats", 64'(accepted), 64'd8);
        check("t3_not_early", 64'(out_valid), 64'd0);
        check("t3_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("t3_latency", 64'(out_valid), 64'd1);
        check("t3_acc", acc_out, 64'h0100_0100_0100_0100);
        check("t3_bin", 64'(bin_out), 64'hF);

        // Output backpressure, starts pulsed and ignored
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b0;
            n_words = 7'd3;
            start = (i % 3 == 0);
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_acc", acc_out, 64'h0100_0100_0100_0100);
            check("bp_busy", 64'(busy), 64'd1);
        end
        start = 1'b1;
        handshake();
        start = 1'b0;
        check("bp_busy_drop", 64'(busy), 64'd0);
        check("bp_valid_drop", 64'(out_valid), 64'd0);
        tick();
        check("bp_start_ignored", 64'(busy), 64'd0);
        check("bp_acc_held", acc_out, 64'h0100_0100_0100_0100);

        // Zero-length job
        start_job(7'd0);
        check("z_no_valid_yet", 64'(out_valid), 64'd0);
        check("z_busy", 64'(busy), 64'd1);
        tick();
        check("z_valid", 64'(out_valid), 64'd1);
        check("z_acc", acc_out, 64'd0);
        check("z_bin", 64'(bin_out), 64'hF);
        handshake();

        // Clamp: MAX_WORDS+5 requested, MAX_WORDS accepted
        start_job(7'd69);
        a_word = 32'hC3A5_5A3C;
        w_words = {4{32'hC3A5_5A3C}};
        accepted = 0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            in_valid = 1'b1;
            rdy = in_ready;
            tick();
            if (rdy) accepted++;
            cyc++;
        end
        in_valid = 1'b0;
        check("cl_timeout", 64'(out_valid), 64'd1);
        check("cl_beats", 64'(accepted), 64'd64);
        check("cl_acc", acc_out, 64'h0800_0800_0800_0800);
        handshake();

        // Reset mid-job
        start_job(7'd8);
        feed(32'h0000_FFFF, {4{32'h0000_FFFF}}, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_in_ready", 64'(in_ready), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_acc", acc_out, 64'd0);
        check("mr_bin", 64'(bin_out), 64'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            tick();
            check("mr_no_output", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;
        start_job(7'd2);
        feed(32'h8001_7FFE, {4{32'h8001_7FFE}}, 2);
        wait_out("mr2_timeout", 4);
        check("mr2_acc", acc_out, 64'h0040_0040_0040_0040);
        handshake();

        // Zero accumulations against thresholds {-1,0,1,32}
`ifdef BNN_THRESH_EN
        thresh = 64'h0020_0001_0000_FFFF;
`endif
        start_job(7'd1);
`ifdef BNN_THRESH_EN
        thresh = '0;
`endif
        feed(32'hFFFF_FFFF, {4{32'hAAAA_AAAA}}, 1);
        wait_out("th_timeout", 4);
        check("th_acc", acc_out, 64'd0);
`ifdef BNN_THRESH_EN
        check("th_bin", 64'(bin_out), 64'b0011);
`else
        check("th_bin", 64'(bin_out), 64'hF);
`endif
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
